// File: rtl/stage_ma_if.sv
`default_nettype none
// stage_ma_if -- data-memory request/response bundle between the MA stage and memory.
// Rev 1.0
interface stage_ma_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface
`default_nettype wire

// File: rtl/stage_ma.sv
`default_nettype none
// stage_ma -- memory-access pipeline stage: load/store handshake with timeout, load formatting, write-back select.
// Rev 1.0
module stage_ma #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] busc_in,
  input  logic [31:0] busb_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  op_in,
  output logic        stall_out,
  stage_ma_if.master  dmem,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic [6:0]  op_out,
  output logic        wb_en_out,
  output logic        misalign_out,
  output logic        bus_err_out
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt;

  logic        is_load, is_store, is_mem, is_wb, misalign, req_go;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, wb_sel;

  logic [31:0] lat_busc;
  logic [1:0]  lat_sz;
  logic        lat_uns, lat_load;
  logic [4:0]  lat_rd;
  logic [6:0]  lat_op;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        done, abort;

  // Decode of the instruction currently presented by EX/MA.
  always_comb begin
    is_load  = (op_in == OP_LOAD);
    is_store = (op_in == OP_STORE);
    is_mem   = is_load | is_store;
    is_wb    = is_load | (op_in == OP_JAL) | (op_in == OP_JALR) | (op_in == OP_LUI) |
               (op_in == OP_AUIPC) | (op_in == OP_OP) | (op_in == OP_IMM);

    size = SZ_W;
    if (is_load) begin
      if (funct3_in == 3'd0 || funct3_in == 3'd4)      size = SZ_B;
      else if (funct3_in == 3'd1 || funct3_in == 3'd5) size = SZ_H;
    end else begin
      if (funct3_in == 3'd0)      size = SZ_B;
      else if (funct3_in == 3'd1) size = SZ_H;
    end

    misalign = is_mem & (((size == SZ_H) & busc_in[0]) |
                         ((size == SZ_W) & (busc_in[1:0] != 2'b00)));
    req_go   = is_mem & ~misalign;

    case (size)
      SZ_B: begin
        st_be    = 4'b0001 << busc_in[1:0];
        st_wdata = {4{busb_in[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << busc_in[1:0];
        st_wdata = {2{busb_in[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = busb_in;
      end
    endcase

    if (op_in == OP_JAL || op_in == OP_JALR) wb_sel = pc_in + 32'd4;
    else if (op_in == OP_LUI)                wb_sel = imm_in;
    else                                     wb_sel = busc_in;
  end

  // Load formatting works from the access attributes captured at issue.
  always_comb begin
    ld_byte = dmem.dmem_rdata[{lat_busc[1:0], 3'b000} +: 8];
    ld_half = lat_busc[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (lat_sz)
      SZ_B:    ld_data = {{24{~lat_uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~lat_uns & ld_half[15]}}, ld_half};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // An ack on the final allowed cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_go) begin
          stall_out = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (dmem.dmem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt == TIMEOUT_C) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= 8'd0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_wdata <= 32'd0;
      dmem.dmem_be    <= 4'd0;
      lat_busc        <= 32'd0;
      lat_sz          <= SZ_W;
      lat_uns         <= 1'b0;
      lat_load        <= 1'b0;
      lat_rd          <= 5'd0;
      lat_op          <= 7'd0;
      wb_data_out     <= 32'd0;
      rd_out          <= 5'd0;
      op_out          <= 7'd0;
      wb_en_out       <= 1'b0;
      misalign_out    <= 1'b0;
      bus_err_out     <= 1'b0;
    end else begin
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_go) begin
            cnt             <= 8'd1;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= is_store;
            dmem.dmem_addr  <= {busc_in[31:2], 2'b00};
            dmem.dmem_wdata <= is_store ? st_wdata : 32'd0;
            dmem.dmem_be    <= is_store ? st_be : 4'b1111;
            lat_busc        <= busc_in;
            lat_sz          <= size;
            lat_uns         <= funct3_in[2];
            lat_load        <= is_load;
            lat_rd          <= rd_in;
            lat_op          <= op_in;
            wb_data_out     <= 32'd0;
            rd_out          <= 5'd0;
            op_out          <= 7'd0;
            wb_en_out       <= 1'b0;
          end else begin
            wb_data_out  <= wb_sel;
            rd_out       <= rd_in;
            op_out       <= op_in;
            wb_en_out    <= is_wb & (rd_in != 5'd0) & ~misalign;
            misalign_out <= misalign;
          end
        end
        WAIT: begin
          if (done) begin
            cnt           <= 8'd0;
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            wb_data_out   <= lat_load ? ld_data : lat_busc;
            rd_out        <= lat_rd;
            op_out        <= lat_op;
            wb_en_out     <= lat_load & (lat_rd != 5'd0);
          end else if (abort) begin
            cnt           <= 8'd0;
            dmem.dmem_req <= 1'b0;
            dmem.dmem_we  <= 1'b0;
            bus_err_out   <= 1'b1;
            wb_data_out   <= 32'd0;
            rd_out        <= 5'd0;
            op_out        <= 7'd0;
            wb_en_out     <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_stage_ma.sv
`default_nettype none
// tb_stage_ma -- randomized self-checking bench for stage_ma against a transaction-level model.
// Rev 1.0
module tb_stage_ma;
  localparam int TIMEOUT = 16;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] busc_in, busb_in, pc_in, imm_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [6:0]  op_in;
  logic        stall_out;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic [6:0]  op_out;
  logic        wb_en_out, misalign_out, bus_err_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_ma_if dmem ();

  stage_ma #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .busc_in      (busc_in),
    .busb_in      (busb_in),
    .pc_in        (pc_in),
    .imm_in       (imm_in),
    .rd_in        (rd_in),
    .funct3_in    (funct3_in),
    .op_in        (op_in),
    .stall_out    (stall_out),
    .dmem         (dmem.master),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .op_out       (op_out),
    .wb_en_out    (wb_en_out),
    .misalign_out (misalign_out),
    .bus_err_out  (bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access width in bytes.
  function automatic int acc_bytes(input logic [6:0] op, input logic [2:0] f3);
    if (op == LOAD) begin
      if (f3 == 0 || f3 == 4) return 1;
      if (f3 == 1 || f3 == 5) return 2;
      return 4;
    end
    if (f3 == 0) return 1;
    if (f3 == 1) return 2;
    return 4;
  endfunction

  function automatic bit writes_back(input logic [6:0] op);
    return op == LOAD || op == JAL || op == JALR || op == LUI ||
           op == AUIPC || op == OPR || op == OPI;
  endfunction

  function automatic logic [31:0] plain_result(input logic [6:0] op, input logic [31:0] a,
                                               input logic [31:0] pc, input logic [31:0] imm);
    if (op == JAL || op == JALR) return pc + 32'd4;
    if (op == LUI) return imm;
    return a;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int          n;
    longint      v;
    n = acc_bytes(LOAD, f3);
    if (n == 4) return rdata;
    v = (rdata >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (f3 < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // One instruction from presentation to retirement; starts and ends 1 time unit after a rising edge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [4:0] rd, input int ack_at, input logic [31:0] rdata);
    bit          mem, mis, late;
    int          n;
    logic [31:0] e_be, e_wd;
    mem  = (op == LOAD || op == STORE);
    n    = acc_bytes(op, f3);
    mis  = mem && (a % n != 0);
    e_be = ((32'd1 << n) - 1) << (a % 4);
    e_wd = (n == 1) ? (b & 32'hFF) * 32'h01010101 :
           (n == 2) ? (b & 32'hFFFF) * 32'h00010001 : b;
    op_in = op; funct3_in = f3; busc_in = a; busb_in = b; pc_in = pc; imm_in = imm; rd_in = rd;
    dmem.dmem_ack   = 1'($urandom_range(0, 1));
    dmem.dmem_rdata = $urandom;
    #1 chk("stall_issue", 32'(stall_out), 32'(mem && !mis));
    if (!mem || mis) begin
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      chk("wb_en", 32'(wb_en_out), 32'(writes_back(op) && rd != 0 && !mis));
      chk("misalign", 32'(misalign_out), 32'(mis));
      chk("bus_err_idle", 32'(bus_err_out), 32'd0);
      chk("no_req", 32'(dmem.dmem_req), 32'd0);
      if (!mis) begin
        chk("wb_data", wb_data_out, plain_result(op, a, pc, imm));
        chk("rd_out", 32'(rd_out), 32'(rd));
      end
    end else begin
      @(posedge clk); #1;
      late = (ack_at < 1 || ack_at > TIMEOUT);
      for (int k = 1; k <= TIMEOUT; k++) begin
        chk("req_held", 32'(dmem.dmem_req), 32'd1);
        chk("addr", dmem.dmem_addr, a - (a % 4));
        chk("we", 32'(dmem.dmem_we), 32'(op == STORE));
        chk("be", 32'(dmem.dmem_be), (op == STORE) ? e_be : 32'hF);
        if (op == STORE) chk("wdata", dmem.dmem_wdata, e_wd);
        chk("wait_bubble", 32'(wb_en_out), 32'd0);
        dmem.dmem_ack   = (k == ack_at);
        dmem.dmem_rdata = (k == ack_at) ? rdata : $urandom;
        #1 chk("stall_wait", 32'(stall_out), 32'(k != ack_at && k != TIMEOUT));
        @(posedge clk); #1;
        dmem.dmem_ack = 1'b0;
        if (k == ack_at) break;
      end
      chk("req_drop", 32'(dmem.dmem_req), 32'd0);
      chk("bus_err", 32'(bus_err_out), 32'(late));
      chk("misalign_mem", 32'(misalign_out), 32'd0);
      chk("wb_en_mem", 32'(wb_en_out), 32'(!late && op == LOAD && rd != 0));
      if (!late && op == LOAD) begin
        chk("load_data", wb_data_out, load_value(f3, a, rdata));
        chk("load_rd", 32'(rd_out), 32'(rd));
      end
    end
  endtask

  initial begin
    logic [6:0] op;
    int         sel;
    int         ack_at;
    op_in = 7'd0; funct3_in = 3'd0; busc_in = 32'd0; busb_in = 32'd0;
    pc_in = 32'd0; imm_in = 32'd0; rd_in = 5'd0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;

    #12;
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_be", 32'(dmem.dmem_be), 32'd0);
    chk("rst_wb_en", 32'(wb_en_out), 32'd0);
    chk("rst_wb_data", wb_data_out, 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(OPR, 3'd0, 32'h55, 32'd0, 32'd0, 32'd0, 5'd5, 0, 32'd0);
    chk("add_data", wb_data_out, 32'h55);
    run_instr(LOAD, 3'd0, 32'h1003, 32'd0, 32'd0, 32'd0, 5'd7, 4, 32'h80FFFFFF);
    chk("lb_data", wb_data_out, 32'hFFFFFF80);
    run_instr(STORE, 3'd1, 32'h2002, 32'h0000BEEF, 32'd0, 32'd0, 5'd0, 2, 32'd0);
    run_instr(LOAD, 3'd2, 32'h3001, 32'd0, 32'd0, 32'd0, 5'd3, 1, 32'd0);
    run_instr(LOAD, 3'd2, 32'h3000, 32'd0, 32'd0, 32'd0, 5'd3, 0, 32'd0);
    run_instr(LOAD, 3'd5, 32'h3002, 32'd0, 32'd0, 32'd0, 5'd9, TIMEOUT, 32'h8001_7FFF);
    run_instr(JAL, 3'd0, 32'h0, 32'd0, 32'hFFFF_FFFC, 32'd0, 5'd1, 0, 32'd0);

    // Reset in the second wait cycle of a store abandons it; a late ack is ignored.
    op_in = STORE; funct3_in = 3'd2; busc_in = 32'h4000; busb_in = 32'h1234_5678; rd_in = 5'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_req_before_rst", 32'(dmem.dmem_req), 32'd1);
    rst_n = 1'b0;
    op_in = 7'd0;
    #1;
    chk("rst_wait_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_wait_we", 32'(dmem.dmem_we), 32'd0);
    chk("rst_wait_addr", dmem.dmem_addr, 32'd0);
    chk("rst_wait_wdata", dmem.dmem_wdata, 32'd0);
    chk("rst_wait_stall", 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem.dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem.dmem_ack = 1'b0;
    chk("late_ack_req", 32'(dmem.dmem_req), 32'd0);
    chk("late_ack_wb_en", 32'(wb_en_out), 32'd0);
    chk("late_ack_stall", 32'(stall_out), 32'd0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1, 2: op = LOAD;
        3, 4:    op = STORE;
        5:       op = JAL;
        6:       op = JALR;
        7:       op = LUI;
        8:       op = AUIPC;
        9:       op = OPR;
        10:      op = OPI;
        default: op = 7'($urandom);
      endcase
      sel = $urandom_range(0, 9);
      if (sel < 7)       ack_at = $urandom_range(1, 4);
      else if (sel == 7) ack_at = TIMEOUT;
      else if (sel == 8) ack_at = TIMEOUT - 1;
      else               ack_at = 0;
      run_instr(op, 3'($urandom), $urandom, $urandom, $urandom, $urandom,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), ack_at, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stage_ma.md
STAGE_MA -- requirements
Module: stage_ma

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles awaiting dmem_ack before abort (range 2..255).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports busc_in 32 (ALU result / address), busb_in 32 (store data), pc_in 32, imm_in 32, rd_in 5, funct3_in 3, op_in 7; all inputs from the EX/MA register.
REQ-005 SHALL have port stall_out  out  1  upstream hold; EX/MA register and earlier stages freeze while high.
REQ-006 SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word aligned, [1:0]=0), dmem_wdata out 32, dmem_be out 4, dmem_rdata in 32, dmem_ack in 1.
REQ-007 SHALL have outputs wb_data_out 32, rd_out 5, op_out 7, wb_en_out 1, misalign_out 1, bus_err_out 1, all registered; they feed MA/WB.

Function
REQ-008 SHALL decode op_in: LOAD 0000011, STORE 0100011 = memory ops; JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, OP 0110011, OP-IMM 0010011 = write-back ops; all others = no write-back.
REQ-009 SHALL compute wb_en = write-back op (incl. LOAD) AND rd_in != 0 AND no misalign/bus error.
REQ-010 SHALL select write-back data: JAL/JALR -> pc_in+4 (mod 2^32); LUI -> imm_in; LOAD -> formatted load data; others -> busc_in.
REQ-011 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-012 IDLE, non-memory op: SHALL register outputs at next edge (latency 1), stall_out=0.
REQ-013 IDLE, memory op aligned: SHALL assert stall_out combinationally, go to WAIT; dmem_req/we/addr/wdata/be registered, valid from first WAIT cycle; outputs load a bubble (wb_en=0, rd=0, op=0, data=0).
REQ-014 WAIT: dmem_req SHALL stay 1 with stable addr/we/wdata/be until dmem_ack; stall_out = NOT dmem_ack.
REQ-015 WAIT with dmem_ack: SHALL drop dmem_req next edge, register load result/rd/op/wb_en, return to IDLE; upstream advances on same edge.
REQ-016 dmem_ack in IDLE SHALL be ignored.
REQ-017 Misalignment: LH/LHU/SH with busc_in[0]=1, LW/SW with busc_in[1:0]!=0 SHALL issue no request, no stall, set misalign_out=1 and wb_en_out=0 for one cycle.
REQ-018 funct3 values 3, 6, 7 on loads and 3..7 on stores SHALL be treated as LW/SW.
REQ-019 Store: SB be=0001<<a[1:0], wdata={4{busb[7:0]}}; SH be=0011<<a[1:0], wdata={2{busb[15:0]}}; SW be=1111, wdata=busb; dmem_we=1.
REQ-020 Load: dmem_we=0, be=1111; LB/LBU select byte rdata[8*a[1:0]+7 -: 8], LH/LHU half at a[1]; sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes rdata.
REQ-021 Wait counter SHALL count WAIT cycles; on reaching TIMEOUT without ack: deassert req, bus_err_out=1 one cycle, wb_en_out=0, stall_out=0 that cycle, return to IDLE.
REQ-022 Ack on exactly cycle TIMEOUT SHALL take priority over timeout.
REQ-023 misalign_out and bus_err_out SHALL be single-cycle pulses, cleared next edge unless re-triggered.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, all registered outputs 0; stall_out=0 unless a memory op is presented in IDLE.
REQ-025 Reset during WAIT SHALL abandon the access with no write-back; late dmem_ack after release SHALL be ignored.

Verification
REQ-026 ADD op=0110011, busc=0x00000055, rd=5 -> next edge wb_data=0x55, rd_out=5, wb_en=1, stall_out=0.
REQ-027 LB addr 0x1003, rdata=0x80FFFFFF, ack 3 cycles after req -> stall 4 cycles, wb_data=0xFFFFFF80, wb_en=1.
REQ-028 SH addr 0x2002, busb=0x0000BEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x2000, we=1, wb_en=0.
REQ-029 LW addr 0x3001 -> no dmem_req, misalign_out=1 one cycle, stall_out=0.
REQ-030 LW, no ack, TIMEOUT=16 -> req held 16 cycles, bus_err_out=1 one cycle, then IDLE.
REQ-031 rst_n low in WAIT cycle 2 of SW -> dmem_req=0 immediately, all outputs 0; ack after release ignored.
